// File: rtl/cu_pkg.sv
// Shared definitions for the accumulator-CPU control unit: control-bit indices,
// opcodes and the 5-bit state encoding.
package cu_pkg;

  localparam int CW = 32;

  localparam int CS_PC_INC   = 0;
  localparam int CS_PC_LOAD  = 1;
  localparam int CS_MAR_PC   = 2;
  localparam int CS_MBR_MEM  = 3;
  localparam int CS_IR_MBR   = 4;
  localparam int CS_MAR_MBR  = 5;
  localparam int CS_MEM_MBR  = 6;
  localparam int CS_MBR_ACC  = 7;
  localparam int CS_ACC_MBR  = 8;
  localparam int CS_ALU_ADD  = 9;
  localparam int CS_ALU_SUB  = 10;
  localparam int CS_ACC_ALU  = 11;
  localparam int CS_BR_MBR   = 12;
  localparam int CS_IR_CU    = 13;
  localparam int CS_HALT     = 14;

  localparam logic [7:0] OP_STORE  = 8'h01;
  localparam logic [7:0] OP_LOAD   = 8'h02;
  localparam logic [7:0] OP_ADD    = 8'h03;
  localparam logic [7:0] OP_SUB    = 8'h04;
  localparam logic [7:0] OP_JMP    = 8'h05;
  localparam logic [7:0] OP_JMPGEZ = 8'h06;
  localparam logic [7:0] OP_HALT   = 8'h07;

  typedef enum logic [4:0] {
    S_RST, S_F0, S_F1, S_F2, S_F3, S_O0, S_O1,
    S_ST0, S_ST1, S_ST2,
    S_LD0, S_LD1, S_LD2,
    S_AD0, S_AD1, S_AD2, S_AD3,
    S_SB0, S_SB1, S_SB2, S_SB3,
    S_JMP0, S_JGZ0, S_NOP0, S_HALT
  } state_t;

endpackage

// File: rtl/cu_decode.sv
// Combinational state -> control word. acc_neg only affects the JMPGEZ word.
module cu_decode
  import cu_pkg::*;
(
  input  logic [4:0]    state,
  input  logic          acc_neg,
  output logic [CW-1:0] cw
);

  always_comb begin
    cw = '0;
    case (state_t'(state))
      S_F0, S_O0: cw[CS_MAR_PC] = 1'b1;
      S_F1, S_O1, S_LD1, S_AD1, S_SB1: begin
        cw[CS_MBR_MEM] = (state_t'(state) == S_F1 || state_t'(state) == S_O1) ||
                         1'b1;
        cw[CS_PC_INC]  = (state_t'(state) == S_F1 || state_t'(state) == S_O1);
      end
      S_F2:   cw[CS_IR_MBR] = 1'b1;
      S_F3:   cw[CS_IR_CU]  = 1'b1;
      S_ST0, S_LD0, S_AD0, S_SB0: cw[CS_MAR_MBR] = 1'b1;
      S_ST1:  cw[CS_MBR_ACC] = 1'b1;
      S_ST2:  cw[CS_MEM_MBR] = 1'b1;
      S_LD2:  cw[CS_ACC_MBR] = 1'b1;
      S_AD2, S_SB2: cw[CS_BR_MBR] = 1'b1;
      S_AD3: begin
        cw[CS_ALU_ADD] = 1'b1;
        cw[CS_ACC_ALU] = 1'b1;
      end
      S_SB3: begin
        cw[CS_ALU_SUB] = 1'b1;
        cw[CS_ACC_ALU] = 1'b1;
      end
      S_JMP0: cw[CS_PC_LOAD] = 1'b1;
      // Branch taken only when the accumulator is non-negative.
      S_JGZ0: cw[CS_PC_LOAD] = ~acc_neg;
      S_HALT: cw[CS_HALT]    = 1'b1;
      default: cw = '0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Moore control unit: fetch, operand fetch, dispatch on op_q, execute.
// Optional macro CU_ILLEGAL_TRAP_EN: undefined opcodes halt and set illegal_op.
module control_unit
  import cu_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    ir_opcode,
  input  logic          acc_neg,
  output logic [CW-1:0] control_signal,
  output logic          halted,
  output logic          illegal_op
);

  state_t        state_q, state_d;
  logic [7:0]    op_q;
  logic [CW-1:0] cw_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_RST;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      // The IR forwards the opcode one cycle after F3, so it is taken in O0.
      if (state_q == S_O0) op_q <= ir_opcode;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:  state_d = S_F0;
      S_F0:   state_d = S_F1;
      S_F1:   state_d = S_F2;
      S_F2:   state_d = S_F3;
      S_F3:   state_d = S_O0;
      S_O0:   state_d = S_O1;
      S_O1: begin
        case (op_q)
          OP_STORE:  state_d = S_ST0;
          OP_LOAD:   state_d = S_LD0;
          OP_ADD:    state_d = S_AD0;
          OP_SUB:    state_d = S_SB0;
          OP_JMP:    state_d = S_JMP0;
          OP_JMPGEZ: state_d = S_JGZ0;
          OP_HALT:   state_d = S_HALT;
`ifdef CU_ILLEGAL_TRAP_EN
          default:   state_d = S_HALT;
`else
          default:   state_d = S_NOP0;
`endif
        endcase
      end
      S_ST0:  state_d = S_ST1;
      S_ST1:  state_d = S_ST2;
      S_LD0:  state_d = S_LD1;
      S_LD1:  state_d = S_LD2;
      S_AD0:  state_d = S_AD1;
      S_AD1:  state_d = S_AD2;
      S_AD2:  state_d = S_AD3;
      S_SB0:  state_d = S_SB1;
      S_SB1:  state_d = S_SB2;
      S_SB2:  state_d = S_SB3;
      S_ST2, S_LD2, S_AD3, S_SB3, S_JMP0, S_JGZ0, S_NOP0: state_d = S_F0;
      S_HALT: state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  // Decode the state being entered so the registered word matches the state.
  cu_decode u_decode (
    .state   (state_d),
    .acc_neg (acc_neg),
    .cw      (cw_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      control_signal <= '0;
      halted         <= 1'b0;
    end else begin
      control_signal <= cw_next;
      halted         <= (state_d == S_HALT);
    end
  end

`ifdef CU_ILLEGAL_TRAP_EN
  logic illegal_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      illegal_q <= 1'b0;
    else if (state_q == S_O1 && state_d == S_HALT && op_q != OP_HALT)
      illegal_q <= 1'b1;
  end
  assign illegal_op = illegal_q;
`else
  assign illegal_op = 1'b0;
`endif

endmodule
